// File: rtl/pmp_pkg.sv
// Shared types for the PMP check arbiter: checker access encodings,
// requester identity and the configuration-quiesce FSM states.
package pmp_pkg;

    localparam logic [1:0] ACC_X = 2'b00;
    localparam logic [1:0] ACC_R = 2'b01;
    localparam logic [1:0] ACC_W = 2'b11;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } src_type;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        QUIET = 2'd2
    } arb_state_type;

    // Fetches always check execute permission; data accesses check R or W.
    function automatic logic [1:0] acc_of(input src_type src, input logic write);
        logic [1:0] acc;
        if (src == SRC_IF) begin
            acc = ACC_X;
        end else if (write) begin
            acc = ACC_W;
        end else begin
            acc = ACC_R;
        end
        return acc;
    endfunction

endpackage

// File: rtl/pmp_rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins, on a tie the port not granted last wins.
// Grant is combinational; the last-grant pointer only moves when the grant is actually accepted.
module pmp_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    // 1 = data port was granted last; reset value gives fetch the first tie.
    logic last_dm_q;
    logic last_dm_d;

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_dm_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_comb begin
        last_dm_d = last_dm_q;
        if (accept_i && (grant_o != 2'b00)) begin
            last_dm_d = grant_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_dm_q <= 1'b1;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end

endmodule

// File: rtl/pmp_check_arbiter.sv
// Shares one PMP checker between fetch and data ports via round-robin grant; optional PMP_ARB_FAULT_CNT_EN counts denials.
// Latency: accept at E0, checker inputs valid E0..E1, response registered at E1 (2 edges, 1 check/cycle).
// Backpressure: a held response stalls the check stage and drops ready; cfg_req blocks grants and drains both stages.
module pmp_check_arbiter
    import pmp_pkg::*;
#(
    parameter int pmp_msb   = 55,
    parameter int cnt_width = 16
) (
    input  logic                 clk300p,
    input  logic                 rst,
    input  logic                 if_valid,
    output logic                 if_ready,
    input  logic [pmp_msb:0]     if_addr,
    input  logic                 dm_valid,
    output logic                 dm_ready,
    input  logic [pmp_msb:0]     dm_addr,
    input  logic                 dm_write,
    input  logic [1:0]           prv,
    input  logic [1:0]           mpp,
    input  logic                 mprv,
    output logic                 if_rvalid,
    input  logic                 if_rready,
    output logic                 if_rok,
    output logic                 dm_rvalid,
    input  logic                 dm_rready,
    output logic                 dm_rok,
    output logic [pmp_msb:0]     chk_address,
    output logic [1:0]           chk_acc,
    output logic [1:0]           chk_prv,
    output logic [1:0]           chk_mpp,
    output logic                 chk_mprv,
    output logic                 chk_valid,
    input  logic                 chk_ok,
    input  logic                 cfg_req,
    output logic                 cfg_ack,
    input  logic                 fault_clr,
    output logic [cnt_width-1:0] fault_cnt
);

    arb_state_type state_q;
    logic          cfg_ack_q;

    logic            c_valid_q, c_valid_d;
    src_type         c_src_q,   c_src_d;
    logic [pmp_msb:0] c_addr_q, c_addr_d;
    logic [1:0]      c_acc_q,   c_acc_d;
    logic [1:0]      c_prv_q,   c_prv_d;
    logic [1:0]      c_mpp_q,   c_mpp_d;
    logic            c_mprv_q,  c_mprv_d;

    logic    r_valid_q, r_valid_d;
    src_type r_src_q,   r_src_d;
    logic    r_ok_q,    r_ok_d;

    logic [1:0] grant;
    logic       gnt_dm;
    logic       r_free;
    logic       c_adv;
    logic       accept_ok;
    logic       accept;

    assign r_free = !r_valid_q || ((r_src_q == SRC_DM) ? dm_rready : if_rready);
    assign c_adv  = c_valid_q && r_free;

    // Ready is combinational on cfg_req so a new request cannot slip in the cycle quiesce starts.
    assign accept_ok = !rst && (state_q == RUN) && !cfg_req && (!c_valid_q || r_free);
    assign if_ready  = grant[0] && accept_ok;
    assign dm_ready  = grant[1] && accept_ok;
    assign accept    = if_ready || dm_ready;
    assign gnt_dm    = grant[1];

    pmp_rr_arb2 u_arb (
        .clk_i    (clk300p),
        .rst_i    (rst),
        .req_i    ({dm_valid, if_valid}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    always_comb begin
        c_valid_d = c_valid_q;
        c_src_d   = c_src_q;
        c_addr_d  = c_addr_q;
        c_acc_d   = c_acc_q;
        c_prv_d   = c_prv_q;
        c_mpp_d   = c_mpp_q;
        c_mprv_d  = c_mprv_q;
        if (accept) begin
            c_valid_d = 1'b1;
            c_src_d   = gnt_dm ? SRC_DM : SRC_IF;
            c_addr_d  = gnt_dm ? dm_addr : if_addr;
            c_acc_d   = acc_of(gnt_dm ? SRC_DM : SRC_IF, dm_write);
            c_prv_d   = prv;
            c_mpp_d   = mpp;
            // MPRV only redirects loads/stores, never instruction fetch.
            c_mprv_d  = gnt_dm && mprv;
        end else if (c_adv) begin
            c_valid_d = 1'b0;
        end
    end

    always_comb begin
        r_valid_d = r_valid_q;
        r_src_d   = r_src_q;
        r_ok_d    = r_ok_q;
        if (c_adv) begin
            r_valid_d = 1'b1;
            r_src_d   = c_src_q;
            r_ok_d    = chk_ok;
        end else if (r_free) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk300p) begin
        if (rst) begin
            c_valid_q <= 1'b0;
            c_src_q   <= SRC_IF;
            c_addr_q  <= '0;
            c_acc_q   <= 2'b00;
            c_prv_q   <= 2'b00;
            c_mpp_q   <= 2'b00;
            c_mprv_q  <= 1'b0;
            r_valid_q <= 1'b0;
            r_src_q   <= SRC_IF;
            r_ok_q    <= 1'b0;
        end else begin
            c_valid_q <= c_valid_d;
            c_src_q   <= c_src_d;
            c_addr_q  <= c_addr_d;
            c_acc_q   <= c_acc_d;
            c_prv_q   <= c_prv_d;
            c_mpp_q   <= c_mpp_d;
            c_mprv_q  <= c_mprv_d;
            r_valid_q <= r_valid_d;
            r_src_q   <= r_src_d;
            r_ok_q    <= r_ok_d;
        end
    end

    // Ack is only raised once both stages have been observed empty while still requested.
    always_ff @(posedge clk300p) begin
        if (rst) begin
            state_q   <= RUN;
            cfg_ack_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (cfg_req) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!cfg_req) begin
                        state_q <= RUN;
                    end else if (!c_valid_q && !r_valid_q) begin
                        state_q   <= QUIET;
                        cfg_ack_q <= 1'b1;
                    end
                end
                QUIET: begin
                    if (!cfg_req) begin
                        state_q   <= RUN;
                        cfg_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    cfg_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign chk_valid   = c_valid_q;
    assign chk_address = c_addr_q;
    assign chk_acc     = c_acc_q;
    assign chk_prv     = c_prv_q;
    assign chk_mpp     = c_mpp_q;
    assign chk_mprv    = c_mprv_q;

    assign if_rvalid = r_valid_q && (r_src_q == SRC_IF);
    assign dm_rvalid = r_valid_q && (r_src_q == SRC_DM);
    assign if_rok    = r_ok_q;
    assign dm_rok    = r_ok_q;
    assign cfg_ack   = cfg_ack_q;

`ifdef PMP_ARB_FAULT_CNT_EN
    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    logic [cnt_width-1:0] fault_cnt_q;
    logic [cnt_width-1:0] fault_cnt_d;

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (fault_clr) begin
            fault_cnt_d = '0;
        end else if (c_adv && !chk_ok && (fault_cnt_q != '1)) begin
            fault_cnt_d = fault_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk300p) begin
        if (rst) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_cnt = fault_cnt_q;
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
    assign fault_cnt        = '0;
`endif

endmodule
